// File: rtl/collision_ctrl_pkg.sv
// Shared constants for the collision controller: playfield size, game-state
// encoding, default sprite sizes and the scan FSM states.
package collision_ctrl_pkg;

    localparam int GAME_WIDTH  = 640;
    localparam int GAME_HEIGHT = 480;

    localparam logic [1:0] STATE_RUNNING = 2'b01;

    localparam int DEF_CAR_W  = 32;
    localparam int DEF_CAR_H  = 16;
    localparam int DEF_FROG_W = 16;
    localparam int DEF_FROG_H = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_e;

    function automatic logic [2:0] lives_dec(input logic [2:0] lives);
        return (lives == 3'd0) ? 3'd0 : lives - 3'd1;
    endfunction

endpackage

// File: rtl/collision_ctrl_box_overlap.sv
// Combinational car/frog box overlap test. Cars running off the right edge
// wrap to the left, so the spilled part of the car is tested as a second span.
module collision_ctrl_box_overlap
    import collision_ctrl_pkg::*;
#(
    parameter int CAR_W  = DEF_CAR_W,
    parameter int CAR_H  = DEF_CAR_H,
    parameter int FROG_W = DEF_FROG_W,
    parameter int FROG_H = DEF_FROG_H
) (
    input  logic [9:0] car_x_i,
    input  logic [9:0] car_y_i,
    input  logic [9:0] frog_x_i,
    input  logic [9:0] frog_y_i,
    output logic       overlap_o
);

    localparam logic [10:0] CW  = 11'(CAR_W);
    localparam logic [10:0] CH  = 11'(CAR_H);
    localparam logic [10:0] FW  = 11'(FROG_W);
    localparam logic [10:0] FH  = 11'(FROG_H);
    localparam logic [10:0] GWD = 11'(GAME_WIDTH);

    // 11-bit operands so the right/bottom edges never truncate.
    logic [10:0] car_x, car_y, frog_x, frog_y;
    logic [10:0] car_right, car_bottom, frog_right, frog_bottom;
    logic        y_overlap, x_primary, x_wrapped;

    assign car_x       = {1'b0, car_x_i};
    assign car_y       = {1'b0, car_y_i};
    assign frog_x      = {1'b0, frog_x_i};
    assign frog_y      = {1'b0, frog_y_i};
    assign car_right   = car_x + CW;
    assign car_bottom  = car_y + CH;
    assign frog_right  = frog_x + FW;
    assign frog_bottom = frog_y + FH;

    assign y_overlap = (car_y < frog_bottom) && (frog_y < car_bottom);
    assign x_primary = (car_x < frog_right) && (frog_x < car_right);
    // Wrapped span is [0, car_right-GAME_WIDTH-1]; the frog's right edge is always past 0.
    assign x_wrapped = (car_right > GWD) && (frog_x < (car_right - GWD));

    assign overlap_o = y_overlap && (x_primary || x_wrapped);

endmodule

// File: rtl/collision_ctrl.sv
// Per-frame car/frog collision scanner with lives counter and grace window.
// Optional COLLISION_STATS_EN adds a saturating overlap counter o_Hit_Count.
module collision_ctrl
    import collision_ctrl_pkg::*;
#(
    parameter int NUM_CARS     = 8,
    parameter int CAR_W        = DEF_CAR_W,
    parameter int CAR_H        = DEF_CAR_H,
    parameter int FROG_W       = DEF_FROG_W,
    parameter int FROG_H       = DEF_FROG_H,
    parameter int START_LIVES  = 3,
    parameter int GRACE_FRAMES = 60
) (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic       i_Frame_Tick,
    input  logic       i_Restart,
    input  logic [1:0] i_game_state,
    input  logic [9:0] i_frogX,
    input  logic [9:0] i_frogY,
    output logic [3:0] o_Car_Sel,
    input  logic [9:0] i_carX,
    input  logic [9:0] i_carY,
    output logic       o_Hit,
    output logic [3:0] o_Hit_Idx,
    output logic [2:0] o_Lives,
    output logic       o_Game_Over,
    output logic       o_Busy
`ifdef COLLISION_STATS_EN
    ,
    output logic [7:0] o_Hit_Count
`endif
);

    localparam int          GRW      = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES + 1) : 1;
    localparam logic [GRW-1:0] GRACE_LD = GRW'(GRACE_FRAMES);
    localparam logic [3:0]  LAST_SEL = 4'(NUM_CARS - 1);
    localparam logic [2:0]  LIVES_LD = 3'(START_LIVES);

    state_e         state_q, state_d;
    logic [3:0]     sel_q, sel_d;
    logic           any_hit_q, any_hit_d;
    logic [3:0]     pend_q, pend_d;
    logic           hit_q, hit_d;
    logic [3:0]     hit_idx_q, hit_idx_d;
    logic [2:0]     lives_q, lives_d;
    logic           game_over_q, game_over_d;
    logic [GRW-1:0] grace_q, grace_d;
`ifdef COLLISION_STATS_EN
    logic [7:0]     count_q, count_d;
`endif

    logic car_overlap;
    logic running;
    logic scan_start;
    logic last_car;
    logic accept;

    collision_ctrl_box_overlap #(
        .CAR_W  (CAR_W),
        .CAR_H  (CAR_H),
        .FROG_W (FROG_W),
        .FROG_H (FROG_H)
    ) u_overlap (
        .car_x_i   (i_carX),
        .car_y_i   (i_carY),
        .frog_x_i  (i_frogX),
        .frog_y_i  (i_frogY),
        .overlap_o (car_overlap)
    );

    assign running    = (i_game_state == STATE_RUNNING);
    assign scan_start = (state_q == IDLE) && i_Frame_Tick && running && !game_over_q;
    assign last_car   = (sel_q == LAST_SEL);
    assign accept     = (state_q == REPORT) && any_hit_q && (grace_q == '0);

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (scan_start) state_d = SCAN;
            SCAN:    if (last_car) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_Restart) state_d = IDLE;
    end

    always_comb begin
        o_Busy = (state_q == SCAN) || (state_q == REPORT);
    end

    always_comb begin
        sel_d       = sel_q;
        any_hit_d   = any_hit_q;
        pend_d      = pend_q;
        hit_d       = 1'b0;
        hit_idx_d   = hit_idx_q;
        lives_d     = lives_q;
        grace_d     = grace_q;
        game_over_d = (lives_q == 3'd0);
`ifdef COLLISION_STATS_EN
        count_d     = count_q;
`endif

        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    sel_d     = 4'd0;
                    any_hit_d = 1'b0;
                end
            end
            SCAN: begin
                // First overlap in ascending index order is the one kept.
                if (car_overlap && !any_hit_q) begin
                    any_hit_d = 1'b1;
                    pend_d    = sel_q;
                end
                sel_d = last_car ? 4'd0 : sel_q + 4'd1;
            end
            REPORT: begin
                sel_d = 4'd0;
                if (accept) begin
                    hit_d     = 1'b1;
                    hit_idx_d = pend_q;
                    lives_d   = lives_dec(lives_q);
                end
`ifdef COLLISION_STATS_EN
                if (any_hit_q && (count_q != 8'hFF)) count_d = count_q + 8'd1;
`endif
            end
            default: sel_d = 4'd0;
        endcase

        if (i_Frame_Tick && running && (grace_q != '0)) grace_d = grace_q - GRW'(1);
        if (accept) grace_d = GRACE_LD;

        if (i_Restart) begin
            sel_d       = 4'd0;
            any_hit_d   = 1'b0;
            hit_d       = 1'b0;
            hit_idx_d   = hit_idx_q;
            lives_d     = LIVES_LD;
            grace_d     = '0;
            game_over_d = 1'b0;
`ifdef COLLISION_STATS_EN
            count_d     = 8'd0;
`endif
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sel_q       <= 4'd0;
            any_hit_q   <= 1'b0;
            pend_q      <= 4'd0;
            hit_q       <= 1'b0;
            hit_idx_q   <= 4'd0;
            lives_q     <= LIVES_LD;
            grace_q     <= '0;
            game_over_q <= 1'b0;
`ifdef COLLISION_STATS_EN
            count_q     <= 8'd0;
`endif
        end else begin
            sel_q       <= sel_d;
            any_hit_q   <= any_hit_d;
            pend_q      <= pend_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            lives_q     <= lives_d;
            grace_q     <= grace_d;
            game_over_q <= game_over_d;
`ifdef COLLISION_STATS_EN
            count_q     <= count_d;
`endif
        end
    end

    assign o_Car_Sel   = sel_q;
    assign o_Hit       = hit_q;
    assign o_Hit_Idx   = hit_idx_q;
    assign o_Lives     = lives_q;
    assign o_Game_Over = game_over_q;
`ifdef COLLISION_STATS_EN
    assign o_Hit_Count = count_q;
`endif

endmodule

// File: tb/tb_collision_ctrl.sv
// Self-checking bench for collision_ctrl: per-frame expected results are
// queued when a tick is driven and compared when the scan finishes.
module tb_collision_ctrl;

    localparam int N      = 8;
    localparam int START  = 3;
    localparam int GRACE  = 60;
    localparam int GWIDTH = 640;
    localparam int CW     = 32;
    localparam int CH     = 16;
    localparam int FW     = 16;
    localparam int FH     = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] gs = 2'b01;
    logic [9:0] frog_x = 10'd100;
    logic [9:0] frog_y = 10'd200;
    logic [3:0] sel;
    logic [9:0] car_x_bus, car_y_bus;
    logic [9:0] car_x [16];
    logic [9:0] car_y [16];
    logic       hit;
    logic [3:0] hit_idx;
    logic [2:0] lives;
    logic       game_over;
    logic       busy;
`ifdef COLLISION_STATS_EN
    logic [7:0] hit_count;
`endif

    assign car_x_bus = car_x[sel];
    assign car_y_bus = car_y[sel];

    collision_ctrl dut (
        .i_Clk        (clk),
        .i_Reset_n    (rst_n),
        .i_Frame_Tick (tick),
        .i_Restart    (restart),
        .i_game_state (gs),
        .i_frogX      (frog_x),
        .i_frogY      (frog_y),
        .o_Car_Sel    (sel),
        .i_carX       (car_x_bus),
        .i_carY       (car_y_bus),
        .o_Hit        (hit),
        .o_Hit_Idx    (hit_idx),
        .o_Lives      (lives),
        .o_Game_Over  (game_over),
        .o_Busy       (busy)
`ifdef COLLISION_STATS_EN
        ,
        .o_Hit_Count  (hit_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_lives, m_grace, m_idx, m_count;
    int total_hits = 0;
    logic [7:0] exp_q [$];
    logic       busy_prev = 1'b0;
    logic [7:0] e;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit ref_overlap(input int cx, input int cy, input int fx, input int fy);
        bit y_ok, x_ok;
        y_ok = (cy < fy + FH) && (fy < cy + CH);
        x_ok = (cx < fx + FW) && (fx < cx + CW);
        if (cx + CW > GWIDTH) x_ok = x_ok || (fx <= cx + CW - GWIDTH - 1);
        return y_ok && x_ok;
    endfunction

    task automatic place_far();
        for (int i = 0; i < 16; i++) begin
            car_x[i] = 10'd400;
            car_y[i] = 10'd20;
        end
    endtask

    task automatic model_restart();
        m_lives = START;
        m_grace = 0;
        m_count = 0;
    endtask

    task automatic do_restart();
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
        model_restart();
    endtask

    // One frame: predict, push, drive tick, watch for the pulse.
    task automatic run_frame(input int drop_at, input int restart_at);
        int  first, hit_at, hit_cycles;
        bit  start, exp_hit, busy_seen;
        first = -1; exp_hit = 1'b0; hit_at = -1; hit_cycles = 0; busy_seen = 1'b0;
        if (m_grace > 0) m_grace--;
        start = (m_lives != 0);
        if (start) begin
            for (int i = 0; i < N; i++)
                if (first < 0 && ref_overlap(int'(car_x[i]), int'(car_y[i]), int'(frog_x), int'(frog_y)))
                    first = i;
            if (restart_at > 0) begin
                model_restart();
            end else if (first >= 0) begin
                if (m_count < 255) m_count++;
                if (m_grace == 0) begin
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    m_idx   = first;
                    m_grace = GRACE;
                    exp_hit = 1'b1;
                end
            end
            exp_q.push_back({exp_hit, 4'(m_idx), 3'(m_lives)});
        end
        @(negedge clk) tick = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) tick = 1'b0;
            if (c == drop_at) gs = 2'b00;
            restart = (c == restart_at);
            if (busy) busy_seen = 1'b1;
            if (hit) begin
                hit_cycles++;
                if (hit_at < 0) hit_at = c;
            end
        end
        gs = 2'b01;
        restart = 1'b0;
        total_hits += hit_cycles;
        if (start) check("hit_width", hit_cycles, exp_hit ? 1 : 0);
        if (start && exp_hit) check("hit_latency", hit_at, 10);
        if (!start) check("no_scan_busy", busy_seen, 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", {24'd0, hit, hit_idx, lives}, {24'd0, e});
                end
            end
            busy_prev = busy;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits0, fx, bit_found;
        place_far();
        model_restart();
        m_idx = 0;
        repeat (3) @(negedge clk);
        check("rst_lives", lives, START);
        check("rst_hit", hit, 0);
        check("rst_idx", hit_idx, 0);
        check("rst_game_over", game_over, 0);
        check("rst_busy", busy, 0);
        check("rst_sel", sel, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single overlapping car
        car_x[3] = 10'd90; car_y[3] = 10'd195;
        run_frame(0, 0);
        check("lives_after_hit", lives, 2);

        // two overlaps, lowest index wins
        do_restart(); place_far();
        car_x[2] = 10'd95;  car_y[2] = 10'd190;
        car_x[5] = 10'd110; car_y[5] = 10'd205;
        run_frame(0, 0);

        // wrap-around car at x=630 against several frog positions
        for (int k = 0; k < 4; k++) begin
            int fxs [4] = '{5, 30, 21, 22};
            do_restart(); place_far();
            car_x[6] = 10'd630; car_y[6] = 10'd200;
            frog_x = 10'(fxs[k]);
            run_frame(0, 0);
        end
        frog_x = 10'd100;

        // persistent overlap: grace window
        do_restart(); place_far();
        car_x[3] = 10'd90; car_y[3] = 10'd195;
        hits0 = total_hits;
        repeat (61) run_frame(0, 0);
        check("grace_two_hits", total_hits - hits0, 2);
        check("grace_lives", lives, 1);
`ifdef COLLISION_STATS_EN
        check("stats_count", hit_count, m_count);
`endif
        repeat (60) run_frame(0, 0);
        check("lives_zero", lives, 0);
        check("game_over_set", game_over, 1);
        run_frame(0, 0);
        do_restart();
        check("restart_lives", lives, START);
        check("restart_game_over", game_over, 0);

        // restart in the REPORT cycle wins over the hit
        run_frame(0, 9);
        check("restart_priority_lives", lives, START);

        // leaving running mid-scan still reports
        do_restart();
        run_frame(3, 0);
        check("drop_run_lives", lives, 2);

        // not running: tick starts nothing
        gs = 2'b00;
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        bit_found = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy) bit_found = 1;
        end
        check("not_running_idle", bit_found, 0);
        gs = 2'b01;

        // random frames
        for (int r = 0; r < 20; r++) begin
            do_restart(); place_far();
            frog_x = 10'($urandom_range(40, 600));
            frog_y = 10'($urandom_range(40, 400));
            for (int j = 0; j < 3; j++) begin
                int ci;
                ci = $urandom_range(0, N - 1);
                fx = int'(frog_x) + $urandom_range(0, 70) - 45;
                car_x[ci] = 10'(fx);
                car_y[ci] = 10'(int'(frog_y) + $urandom_range(0, 40) - 20);
            end
            run_frame(0, 0);
        end

        // asynchronous reset mid-scan
        do_restart();
        @(negedge clk) tick = 1'b1;
        bit_found = 0;
        for (int c = 1; c <= 20 && !bit_found; c++) begin
            @(negedge clk);
            if (c == 1) tick = 1'b0;
            if (sel == 4'd4) bit_found = 1;
        end
        check("sel_reaches_4", bit_found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_sel", sel, 0);
        check("async_rst_lives", lives, START);
        check("async_rst_hit_idx", hit_idx, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_restart();
        m_idx = 0;
        place_far();
        car_x[1] = 10'd100; car_y[1] = 10'd200;
        frog_x = 10'd100; frog_y = 10'd200;
        run_frame(0, 0);
`ifdef COLLISION_STATS_EN
        check("stats_final", hit_count, m_count);
`endif

        repeat (3) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/collision_ctrl.md
Name: collision_ctrl

Overview:
- Consumer end of the car position interface. Once per frame it scans all car positions through a select/mux, tests each against the frog box, and turns an overlap into a hit.
- It also owns the lives counter and the post-hit grace window. It drives hit and game-over outputs to the game-state FSM.
- Placement: between the car_ctrl instances (via an external combinational mux) and the top-level game FSM.

Parameters:
- NUM_CARS, 8, number of car_ctrl instances scanned (1..16)
- CAR_W, 32, car width in pixels
- CAR_H, 16, car height in pixels
- FROG_W, 16, frog width in pixels
- FROG_H, 16, frog height in pixels
- START_LIVES, 3, lives after reset/restart (1..7)
- GRACE_FRAMES, 60, frames during which hits are ignored after a hit

Ports:
- i_Clk in 1: system clock
- i_Reset_n in 1: reset, asynchronous, active-low
- i_Frame_Tick in 1: one-cycle pulse per video frame
- i_Restart in 1: synchronous; restores lives and clears grace
- i_game_state in 2: 2'b01 = running; scans only start while running
- i_frogX in 10: frog left edge
- i_frogY in 10: frog top edge
- o_Car_Sel out 4: index driven to the external car mux
- i_carX in 10: X of the selected car, valid in the same cycle as o_Car_Sel
- i_carY in 10: Y of the selected car, valid in the same cycle as o_Car_Sel
- o_Hit out 1: one-cycle pulse on an accepted collision
- o_Hit_Idx out 4: lowest colliding car index, held until the next accepted hit
- o_Lives out 3: remaining lives
- o_Game_Over out 1: high while o_Lives == 0
- o_Busy out 1: high during SCAN and REPORT

Behaviour:
- Reset values: state IDLE, o_Car_Sel=0, o_Hit=0, o_Hit_Idx=0, o_Lives=START_LIVES, o_Game_Over=0, grace=0, any_hit=0.
- State IDLE:
  - Enter SCAN on i_Frame_Tick && i_game_state==2'b01 && !o_Game_Over; set o_Car_Sel=0 and clear any_hit.
  - Otherwise remain in IDLE.
- State SCAN:
  - Each cycle, evaluate the car at o_Car_Sel. On overlap with !any_hit, set any_hit and record the index into a pending register. Lowest index wins.
  - If o_Car_Sel==NUM_CARS-1, go to REPORT; else increment o_Car_Sel.
  - SCAN lasts exactly NUM_CARS cycles.
- State REPORT (1 cycle):
  - If any_hit && grace==0: pulse o_Hit next cycle, load o_Hit_Idx from pending, decrement o_Lives (saturate at 0), set grace=GRACE_FRAMES.
  - Return to IDLE; o_Car_Sel returns to 0.
- Grace counter:
  - Decrements by 1 on each i_Frame_Tick while nonzero and running, in any state.
  - A hit found while grace>0 is dropped silently: no pulse and no lives change.
- Overlap test (11-bit arithmetic, no truncation):
  - Y overlap: carY < frogY+FROG_H && frogY < carY+CAR_H.
  - X overlap, primary span: carX < frogX+FROG_W && frogX < carX+CAR_W.
  - Wrap: if carX+CAR_W > GAME_WIDTH, also test the wrapped span [0, carX+CAR_W-GAME_WIDTH-1] against the frog.
  - Hit = Y overlap && (primary X || wrapped X).
- Boundaries:
  - i_Frame_Tick during SCAN/REPORT is ignored for scan start, but still counts toward grace.
  - i_game_state leaving running mid-scan: scan completes and REPORT still applies.
  - i_Restart has priority over REPORT in the same cycle: o_Lives=START_LIVES, grace=0, o_Game_Over=0, state IDLE, no o_Hit.
  - o_Game_Over asserts the cycle after o_Lives reaches 0. No further scans start until restart.
  - Reset mid-scan: immediate return to reset values.
- Latency: tick → o_Hit is NUM_CARS+2 cycles (tick cycle, N scan cycles, REPORT, registered pulse).

Optional Feature:
- Macro: COLLISION_STATS_EN.
- Defined: adds output o_Hit_Count (8 bits, reset 0, saturating at 255). It increments on every overlap detected in REPORT, including hits dropped during grace; i_Restart clears it.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- constants.v: GAME_WIDTH (640), GAME_HEIGHT, state encoding STATE_RUNNING=2'b01, default sprite sizes, FSM state localparams IDLE/SCAN/REPORT.
- Sub-module box_overlap: combinational, parameterised by widths, holds the wrap-aware X/Y overlap test. collision_ctrl instantiates it once.

Test Plan:
- Frog (100,200), car 3 at (90,195), other cars far away, one tick → o_Hit pulse at cycle 10 after tick, o_Hit_Idx=3, o_Lives 3→2.
- Cars 2 and 5 both overlapping → o_Hit_Idx=2, single decrement.
- Car at X=630 (wraps to 0..21), frog at X=5, Y overlapping → hit. Same car with frog at X=30 → no hit.
- Persistent overlap over 61 ticks → exactly two hits: tick 1, then the first tick after 60 grace frames expire. o_Lives=1.
- Three accepted hits → o_Lives=0, o_Game_Over=1, later ticks give o_Busy=0. Then i_Restart → o_Lives=3, o_Game_Over=0.
- i_Reset_n low mid-SCAN at o_Car_Sel=4 → state IDLE, o_Car_Sel=0, o_Lives=3 immediately, without a clock edge.
